// File: rtl/arith_dec_pkg.sv
// Shared constants and state encoding for the arithmetic decoder slice.
package arith_dec_pkg;

  // Smallest probability mass any symbol is guaranteed, in range units.
  localparam int EC_MIN_PROB = 4;

  // Probabilities arrive in Q15; only the top 9 bits feed the multiplier.
  localparam int EC_PROB_SHIFT = 6;

  // Width of the dif window register.
  localparam int EC_WINDOW_SIZE = 32;

  // Signed width of the bit-count register.
  localparam int EC_CNT_WIDTH = 7;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    READY  = 2'd1,
    SEARCH = 2'd2,
    REFILL = 2'd3
  } dec_state_e;

endpackage

// File: rtl/dec_normalize.sv
// Renormalizes rng/dif after a decision: leading-one detect, then shift both registers left.
module dec_normalize #(
  parameter int RANGE_WIDTH  = 16,
  parameter int WINDOW_WIDTH = 32,
  parameter int SHIFT_WIDTH  = $clog2(RANGE_WIDTH) + 1
) (
  input  logic [RANGE_WIDTH-1:0]  rng_i,
  input  logic [WINDOW_WIDTH-1:0] dif_i,
  output logic [SHIFT_WIDTH-1:0]  shift_o,
  output logic [RANGE_WIDTH-1:0]  rng_o,
  output logic [WINDOW_WIDTH-1:0] dif_o
);

  logic [SHIFT_WIDTH-1:0] ilog;

  // Leading-one detector: ilog is the bit length of rng (0 when rng is zero).
  always_comb begin
    ilog = '0;
    for (int i = 0; i < RANGE_WIDTH; i++) begin
      if (rng_i[i]) begin
        ilog = SHIFT_WIDTH'(i + 1);
      end
    end
  end

  assign shift_o = SHIFT_WIDTH'(RANGE_WIDTH) - ilog;
  assign rng_o   = rng_i << shift_o;
  // Shifting dif+1 and subtracting 1 pulls ones into the vacated low bits.
  assign dif_o   = ((dif_i + WINDOW_WIDTH'(1)) << shift_o) - WINDOW_WIDTH'(1);

endmodule

// File: rtl/arithmetic_decoder.sv
// Range/window arithmetic decoder: boolean and multi-symbol (icdf search) decoding
// with byte-wise window refill.
module arithmetic_decoder
  import arith_dec_pkg::*;
#(
  parameter int GENERAL_RANGE_WIDTH  = 16,
  parameter int GENERAL_WINDOW_WIDTH = EC_WINDOW_SIZE,
  parameter int GENERAL_SYMBOL_WIDTH = 4
) (
  input  logic                            general_clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [7:0]                      byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_bool,
  input  logic [GENERAL_RANGE_WIDTH-1:0]  req_fl,
  input  logic [GENERAL_SYMBOL_WIDTH:0]   req_nsyms,
  output logic [GENERAL_SYMBOL_WIDTH-1:0] icdf_addr,
  input  logic [GENERAL_RANGE_WIDTH-1:0]  icdf_data,
  output logic                            resp_valid,
  output logic [GENERAL_SYMBOL_WIDTH-1:0] resp_symbol
);

  localparam int RW  = GENERAL_RANGE_WIDTH;
  localparam int WW  = GENERAL_WINDOW_WIDTH;
  localparam int SW  = GENERAL_SYMBOL_WIDTH;
  localparam int CW  = EC_CNT_WIDTH;
  localparam int SHW = $clog2(RW) + 1;

  localparam logic [RW-1:0]        RNG_INIT = RW'(1) << (RW - 1);
  localparam logic [WW-1:0]        DIF_INIT = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [CW-1:0] CNT_INIT = -7'sd15;

  dec_state_e              state_q, state_d;
  logic [RW-1:0]           rng_q, rng_d;
  logic [WW-1:0]           dif_q, dif_d;
  logic signed [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]           k_q, k_d;
  logic [SW:0]             nsyms_q, nsyms_d;
  logic [RW-1:0]           vPrev_q, vPrev_d;
  logic                    respValid_q, respValid_d;
  logic [SW-1:0]           respSymbol_q, respSymbol_d;
  logic [1:0]              rstSync_q;
  logic                    run;

  logic [RW-1:0]           probSel, minProb, vCur, cTop, uSel, rngDec, rngNorm;
  logic [2*RW-1:0]         product;
  logic [SW:0]             remaining;
  logic [WW-1:0]           vShift, difDec, difNorm, byteShifted;
  logic [SHW-1:0]          normShift;
  logic [SW-1:0]           symbolDec;
  logic [4:0]              byteShift;
  logic signed [CW-1:0]    cntDec, cntFill;
  logic                    hit, lastK, stopSearch;

  // Two-flop synchronizer so the core only starts on the second edge after reset release.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign run = rstSync_q[1];

  // One shared multiplier serves the boolean decision (READY) and each icdf search step (SEARCH).
  always_comb begin
    probSel    = (state_q == SEARCH) ? icdf_data : req_fl;
    remaining  = nsyms_q - (SW+1)'(1) - {1'b0, k_q};
    minProb    = (state_q == SEARCH) ? RW'(EC_MIN_PROB) * RW'(remaining) : RW'(EC_MIN_PROB);
    product    = (2*RW)'(rng_q >> 8) * (2*RW)'(probSel >> EC_PROB_SHIFT);
    vCur       = RW'(product >> (7 - EC_PROB_SHIFT)) + minProb;
    cTop       = dif_q[WW-1 -: RW];
    hit        = cTop >= vCur;
    vShift     = {vCur, {(WW-RW){1'b0}}};
    uSel       = (k_q == '0) ? rng_q : vPrev_q;
    lastK      = ({1'b0, k_q} == (nsyms_q - (SW+1)'(1))) || (&k_q);
    stopSearch = hit || lastK;
    if (state_q == SEARCH) begin
      symbolDec = k_q;
      rngDec    = uSel - vCur;
      difDec    = dif_q - vShift;
    end else if (hit) begin
      symbolDec = '0;
      rngDec    = rng_q - vCur;
      difDec    = dif_q - vShift;
    end else begin
      symbolDec = SW'(1);
      rngDec    = vCur;
      difDec    = dif_q;
    end
    cntDec      = cnt_q - $signed(CW'(normShift));
    byteShift   = 5'(8 - cnt_q);
    byteShifted = WW'(byte_in) << byteShift;
    cntFill     = cnt_q + 7'sd8;
  end

  dec_normalize #(
    .RANGE_WIDTH (RW),
    .WINDOW_WIDTH(WW),
    .SHIFT_WIDTH (SHW)
  ) u_normalize (
    .rng_i  (rngDec),
    .dif_i  (difDec),
    .shift_o(normShift),
    .rng_o  (rngNorm),
    .dif_o  (difNorm)
  );

  // Next-state logic: init has top priority, then byte fill, request accept, and search steps.
  always_comb begin
    state_d      = state_q;
    rng_d        = rng_q;
    dif_d        = dif_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    nsyms_d      = nsyms_q;
    vPrev_d      = vPrev_q;
    respValid_d  = 1'b0;
    respSymbol_d = respSymbol_q;
    if (init) begin
      state_d      = FILL;
      rng_d        = RNG_INIT;
      dif_d        = DIF_INIT;
      cnt_d        = CNT_INIT;
      k_d          = '0;
      vPrev_d      = '0;
      respSymbol_d = '0;
    end else if (run) begin
      unique case (state_q)
        FILL, REFILL: begin
          if (byte_valid) begin
            dif_d = dif_q ^ byteShifted;
            cnt_d = cntFill;
            if (cntFill > 7'sd8) begin
              state_d = READY;
            end
          end
        end
        READY: begin
          if (req_valid) begin
            if (req_bool) begin
              rng_d        = rngNorm;
              dif_d        = difNorm;
              cnt_d        = cntDec;
              respValid_d  = 1'b1;
              respSymbol_d = symbolDec;
              state_d      = cntDec[CW-1] ? REFILL : READY;
            end else begin
              nsyms_d = req_nsyms;
              k_d     = '0;
              state_d = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (stopSearch) begin
            rng_d        = rngNorm;
            dif_d        = difNorm;
            cnt_d        = cntDec;
            respValid_d  = 1'b1;
            respSymbol_d = symbolDec;
            k_d          = '0;
            state_d      = cntDec[CW-1] ? REFILL : READY;
          end else begin
            vPrev_d = vCur;
            k_d     = k_q + SW'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State register with asynchronous active-low reset to the fresh-tile values.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      rng_q        <= RNG_INIT;
      dif_q        <= DIF_INIT;
      cnt_q        <= CNT_INIT;
      k_q          <= '0;
      nsyms_q      <= '0;
      vPrev_q      <= '0;
      respValid_q  <= 1'b0;
      respSymbol_q <= '0;
    end else begin
      state_q      <= state_d;
      rng_q        <= rng_d;
      dif_q        <= dif_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      nsyms_q      <= nsyms_d;
      vPrev_q      <= vPrev_d;
      respValid_q  <= respValid_d;
      respSymbol_q <= respSymbol_d;
    end
  end

  assign byte_ready  = run && ((state_q == FILL) || (state_q == REFILL));
  assign req_ready   = run && (state_q == READY);
  assign icdf_addr   = (state_q == SEARCH) ? k_q : '0;
  assign resp_valid  = respValid_q;
  assign resp_symbol = respSymbol_q;

endmodule
